// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared state type and sizing helpers for the serial frame demux
package serial_frame_pkg;
  typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, STOP, ERROR} state_t;
  function automatic int num_ports(input int port_bits);
    return 1 << port_bits;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic int frame_len(input int port_bits, input int len_bits, input int data_bits, input int n);
    return 2 + port_bits + len_bits + n * data_bits;
  endfunction
endpackage

// File: rtl/serial_frame_demux_sipo.sv
// sipo_shifter: serial-in parallel-out shift register with enable and sync clear
module sipo_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  // shift left so the first bit received ends up most significant
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (en) q <= {q[WIDTH-2:0], din};
endmodule

// File: rtl/serial_frame_demux.sv
// serial_frame_demux: decodes framed serial messages into per-port parallel words
module serial_frame_demux
  import serial_frame_pkg::*;
#(
  parameter int PORT_BITS = 2,
  parameter int LEN_BITS  = 4,
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 8,
  localparam int NUM_PORTS = num_ports(PORT_BITS)
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 serIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic [PORT_BITS-1:0] portSel,
  output logic [NUM_PORTS-1:0] outValid,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_BITS-1:0]  errCount
);
  localparam int W  = max3(PORT_BITS, LEN_BITS, DATA_BITS);
  localparam int BW = $clog2(W) + 1;
  state_t state;
  logic [W-1:0] sh;
  logic [W-1:0] nxt;
  logic [BW-1:0] bcnt;
  logic [LEN_BITS-1:0] wcnt;
  logic shift_en, last, unused_msb;
  assign shift_en = state inside {PORT, LEN, DATA};
  assign nxt = {sh[W-2:0], serIn};
  assign unused_msb = sh[W-1];
  sipo_shifter #(.WIDTH(W)) u_sipo (
    .clk(Clk),
    .reset(reset),
    .clr(state == IDLE || state == ERROR),
    .en(shift_en),
    .din(serIn),
    .q(sh)
  );
  // the field currently being shifted ends on this cycle's bit
  always_comb last = (state == PORT) ? bcnt == BW'(PORT_BITS - 1) :
                     (state == LEN)  ? bcnt == BW'(LEN_BITS - 1) :
                                       bcnt == BW'(DATA_BITS - 1);
  // frame sequencing, word assembly and error accounting
  always_ff @(posedge Clk)
    if (reset) begin
      state    <= IDLE;
      dataOut  <= '0;
      portSel  <= '0;
      outValid <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      errCount <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
    end else begin
      outValid <= '0;
      done     <= 1'b0;
      bcnt     <= (shift_en && !last) ? bcnt + BW'(1) : '0;
      case (state)
        IDLE: if (!serIn) begin
          state <= PORT;
          busy  <= 1'b1;
        end
        PORT: if (last) begin
          portSel <= nxt[PORT_BITS-1:0];
          state   <= LEN;
        end
        LEN: if (last) begin
          wcnt  <= nxt[LEN_BITS-1:0];
          state <= (nxt[LEN_BITS-1:0] == '0) ? STOP : DATA;
        end
        DATA: if (last) begin
          dataOut  <= nxt[DATA_BITS-1:0];
          outValid <= NUM_PORTS'(1) << portSel;
          wcnt     <= wcnt - LEN_BITS'(1);
          state    <= (wcnt == LEN_BITS'(1)) ? STOP : DATA;
        end
        STOP: if (serIn) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          error    <= 1'b1;
          errCount <= (errCount == '1) ? errCount : errCount + CNT_BITS'(1);
          state    <= ERROR;
        end
        ERROR: if (serIn) begin
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
